// File: rtl/sma_buffer_ctrl.sv
// Price-buffer write controller: round-robin grant across stocks, per-stock circular
// window pointers, and a two-stage (write, update) pipeline for the moving-stats block.
module sma_buffer_ctrl #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 64,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_STOCKS-1:0]            i_req_valid,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_req_price,
    output logic [NUM_STOCKS-1:0]            o_req_ready,
    input  logic [NUM_STOCKS-1:0]            i_clear,
    input  logic                             i_stall,
    output logic                             o_mem_write_en,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_mem_write_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_write_data,
    output logic                             o_upd_valid,
    output logic [$clog2(NUM_STOCKS)-1:0]    o_upd_stock_id,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] o_upd_count,
    output logic                             o_upd_evict
);
    localparam int SID_W      = $clog2(NUM_STOCKS);
    localparam int PTR_W      = $clog2(BUFFER_SIZE);
    localparam int CNT_W      = $clog2(BUFFER_SIZE+1);
    localparam int ADDR_WIDTH = $clog2(NUM_STOCKS*BUFFER_SIZE);

    logic [PTR_W-1:0]      r_ptr [NUM_STOCKS];
    logic [CNT_W-1:0]      r_cnt [NUM_STOCKS];
    logic [SID_W-1:0]      r_prio;

    logic [NUM_STOCKS-1:0] w_req;
    logic [NUM_STOCKS-1:0] w_grant;
    logic [SID_W-1:0]      w_gnt_id;
    logic                  w_gnt_any;
    logic [PTR_W-1:0]      w_sel_ptr;
    logic [CNT_W-1:0]      w_sel_cnt;
    logic                  w_full;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_price;

    logic                  r_w_valid;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [SID_W-1:0]      r_w_sid;
    logic [CNT_W-1:0]      r_w_cnt;
    logic                  r_w_evict;

    logic                  r_u_valid;
    logic [SID_W-1:0]      r_u_sid;
    logic [CNT_W-1:0]      r_u_cnt;
    logic                  r_u_evict;

    function automatic logic [SID_W-1:0] rr_idx(input logic [SID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_STOCKS) s = s - NUM_STOCKS;
        return SID_W'(s);
    endfunction

    // A stock being cleared is never granted, so clear always wins over an accept.
    always_comb begin
        w_req     = i_req_valid & ~i_clear & {NUM_STOCKS{~(i_stall | i_rst)}};
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_any = 1'b0;
        for (int i = 0; i < NUM_STOCKS; i++) begin
            if (!w_gnt_any && w_req[rr_idx(r_prio, i)]) begin
                w_grant[rr_idx(r_prio, i)] = 1'b1;
                w_gnt_id                   = rr_idx(r_prio, i);
                w_gnt_any                  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_ptr  = r_ptr[w_gnt_id];
        w_sel_cnt  = r_cnt[w_gnt_id];
        w_full     = (w_sel_cnt == CNT_W'(BUFFER_SIZE));
        w_cnt_next = w_full ? w_sel_cnt : w_sel_cnt + 1'b1;
        w_ptr_next = (w_sel_ptr == PTR_W'(BUFFER_SIZE-1)) ? '0 : w_sel_ptr + 1'b1;
        w_addr     = ADDR_WIDTH'(w_gnt_id) * ADDR_WIDTH'(BUFFER_SIZE) + ADDR_WIDTH'(w_sel_ptr);
        w_price    = i_req_price[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio <= '0;
            for (int k = 0; k < NUM_STOCKS; k++) begin
                r_ptr[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            if (w_gnt_any)
                r_prio <= (int'(w_gnt_id) == NUM_STOCKS-1) ? '0 : w_gnt_id + 1'b1;
            for (int k = 0; k < NUM_STOCKS; k++) begin
                if (i_clear[k]) begin
                    r_ptr[k] <= '0;
                    r_cnt[k] <= '0;
                end else if (w_grant[k]) begin
                    r_ptr[k] <= w_ptr_next;
                    r_cnt[k] <= w_cnt_next;
                end
            end
        end
    end

    // In-flight stages carry their own captured values, so clears never disturb them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_w_valid <= 1'b0;
            r_w_addr  <= '0;
            r_w_data  <= '0;
            r_w_sid   <= '0;
            r_w_cnt   <= '0;
            r_w_evict <= 1'b0;
            r_u_valid <= 1'b0;
            r_u_sid   <= '0;
            r_u_cnt   <= '0;
            r_u_evict <= 1'b0;
        end else begin
            r_w_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_w_addr  <= w_addr;
                r_w_data  <= w_price;
                r_w_sid   <= w_gnt_id;
                r_w_cnt   <= w_cnt_next;
                r_w_evict <= w_full;
            end
            r_u_valid <= r_w_valid;
            if (r_w_valid) begin
                r_u_sid   <= r_w_sid;
                r_u_cnt   <= r_w_cnt;
                r_u_evict <= r_w_evict;
            end
        end
    end

    assign o_req_ready      = w_grant;
    assign o_mem_write_en   = r_w_valid;
    assign o_mem_write_addr = r_w_addr;
    assign o_mem_write_data = r_w_data;
    assign o_upd_valid      = r_u_valid;
    assign o_upd_stock_id   = r_u_sid;
    assign o_upd_count      = r_u_cnt;
    assign o_upd_evict      = r_u_evict;
endmodule

// File: tb/tb_sma_buffer_ctrl.sv
// Scoreboard bench for sma_buffer_ctrl: a reference model predicts grants and the
// write/update each accept must produce; a separate monitor checks them as they appear.
module tb_sma_buffer_ctrl;
    logic         clk;
    logic         i_rst;
    logic [3:0]   i_req_valid;
    logic [127:0] i_req_price;
    logic [3:0]   o_req_ready;
    logic [3:0]   i_clear;
    logic         i_stall;
    logic         o_mem_write_en;
    logic [7:0]   o_mem_write_addr;
    logic [31:0]  o_mem_write_data;
    logic         o_upd_valid;
    logic [1:0]   o_upd_stock_id;
    logic [6:0]   o_upd_count;
    logic         o_upd_evict;

    sma_buffer_ctrl #(.NUM_STOCKS(4), .BUFFER_SIZE(64), .DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_price(i_req_price), .o_req_ready(o_req_ready),
        .i_clear(i_clear), .i_stall(i_stall),
        .o_mem_write_en(o_mem_write_en), .o_mem_write_addr(o_mem_write_addr),
        .o_mem_write_data(o_mem_write_data),
        .o_upd_valid(o_upd_valid), .o_upd_stock_id(o_upd_stock_id),
        .o_upd_count(o_upd_count), .o_upd_evict(o_upd_evict)
    );

    typedef struct {
        int          stamp;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
        logic [6:0]  cnt;
        logic        evict;
    } exp_t;

    exp_t wq[$];
    exp_t uq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_ptr[4];
    int   m_cnt[4];
    int   m_prio;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ptr[k] = 0;
            m_cnt[k] = 0;
        end
        m_prio = 0;
        wq.delete();
        uq.delete();
    endtask

    task automatic drive_cycle(input logic [3:0] v, input logic [3:0] clr, input logic st);
        int   g;
        exp_t e;
        logic [31:0] price [4];
        logic [3:0]  exp_ready;
        @(negedge clk);
        i_req_valid = v;
        i_clear     = clr;
        i_stall     = st;
        for (int k = 0; k < 4; k++) begin
            price[k] = $urandom;
            i_req_price[k*32 +: 32] = price[k];
        end
        #1;
        g = -1;
        if (!st) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_prio + i) % 4;
                if (g < 0 && v[k] && !clr[k]) g = k;
            end
        end
        exp_ready = (g < 0) ? 4'b0 : 4'(1 << g);
        check("req_ready", o_req_ready, exp_ready);
        if (g >= 0) begin
            e.stamp = cyc;
            e.addr  = 8'(g*64 + m_ptr[g]);
            e.data  = price[g];
            e.id    = 2'(g);
            e.evict = (m_cnt[g] == 64);
            m_cnt[g] = (m_cnt[g] + 1 > 64) ? 64 : m_cnt[g] + 1;
            m_ptr[g] = (m_ptr[g] + 1) % 64;
            e.cnt   = 7'(m_cnt[g]);
            wq.push_back(e);
            uq.push_back(e);
            m_prio = (g + 1) % 4;
        end
        for (int k = 0; k < 4; k++)
            if (clr[k]) begin
                m_ptr[k] = 0;
                m_cnt[k] = 0;
            end
    endtask

    // Monitor: each accept in cycle c must show its write in c+1 and its update in c+2.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                if (wq.size() > 0 && wq[0].stamp + 1 == cyc) begin
                    e = wq.pop_front();
                    check("write_en", o_mem_write_en, 1'b1);
                    check("write_addr", o_mem_write_addr, e.addr);
                    check("write_data", o_mem_write_data, e.data);
                end else begin
                    check("write_en_idle", o_mem_write_en, 1'b0);
                end
                if (uq.size() > 0 && uq[0].stamp + 2 == cyc) begin
                    e = uq.pop_front();
                    check("upd_valid", o_upd_valid, 1'b1);
                    check("upd_id", o_upd_stock_id, e.id);
                    check("upd_count", o_upd_count, e.cnt);
                    check("upd_evict", o_upd_evict, e.evict);
                end else begin
                    check("upd_valid_idle", o_upd_valid, 1'b0);
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        i_req_valid = 4'hF;
        i_req_price = '0;
        i_clear = '0;
        i_stall = 1'b0;
        model_reset();
        #1;
        check("rst_ready", o_req_ready, 4'b0);
        check("rst_write_en", o_mem_write_en, 1'b0);
        check("rst_upd_valid", o_upd_valid, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        i_req_valid = '0;
        i_rst = 1'b0;

        // single write to stock 2 straight out of reset
        drive_cycle(4'b0100, 4'b0, 1'b0);
        repeat (3) drive_cycle(4'b0, 4'b0, 1'b0);
        // round robin with everyone requesting
        repeat (9) drive_cycle(4'hF, 4'b0, 1'b0);
        // stall while requests pend, then resume
        repeat (3) drive_cycle(4'hF, 4'b0, 1'b1);
        repeat (5) drive_cycle(4'hF, 4'b0, 1'b0);
        // wrap and saturate on stock 1
        repeat (66) drive_cycle(4'b0010, 4'b0, 1'b0);
        // clear collides with a request on stock 0
        drive_cycle(4'b0, 4'h1, 1'b0);
        repeat (10) drive_cycle(4'b0001, 4'b0, 1'b0);
        drive_cycle(4'b0001, 4'b0001, 1'b0);
        drive_cycle(4'b0001, 4'b0, 1'b0);
        repeat (2) drive_cycle(4'b0, 4'b0, 1'b0);

        // async reset between accept and update
        drive_cycle(4'b1000, 4'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_write_en", o_mem_write_en, 1'b1);
        i_rst = 1'b1;
        i_req_valid = 4'hF;
        #1;
        check("async_rst_write_en", o_mem_write_en, 1'b0);
        check("async_rst_upd_valid", o_upd_valid, 1'b0);
        check("async_rst_ready", o_req_ready, 4'b0);
        model_reset();
        repeat (2) @(negedge clk);
        i_req_valid = '0;
        #2;
        i_rst = 1'b0;
        repeat (2) drive_cycle(4'b0, 4'b0, 1'b0);
        drive_cycle(4'b1000, 4'b0, 1'b0);

        // randomized traffic
        repeat (1500) begin
            logic [3:0] v, clr;
            logic       st;
            v   = 4'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            st  = ($urandom_range(0, 3) == 0);
            drive_cycle(v, clr, st);
        end

        repeat (4) drive_cycle(4'b0, 4'b0, 1'b0);
        check("write_queue_drained", 64'(wq.size()), 64'd0);
        check("update_queue_drained", 64'(uq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sma_buffer_ctrl.md
SMA_BUFFER_CTRL -- requirements
Module: sma_buffer_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NUM_STOCKS, 4, number of stocks; BUFFER_SIZE, 64, window depth per stock; DATA_WIDTH, 32, price width.
REQ-002 Localparams SHALL be: SID_W = $clog2(NUM_STOCKS); PTR_W = $clog2(BUFFER_SIZE); CNT_W = $clog2(BUFFER_SIZE+1); ADDR_WIDTH = $clog2(NUM_STOCKS*BUFFER_SIZE).
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst  in  1  reset; asynchronous, active-high.
REQ-005 i_req_valid  in  NUM_STOCKS  per-stock price-update request.
REQ-006 i_req_price  in  NUM_STOCKS*DATA_WIDTH  stock k price at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 o_req_ready  out  NUM_STOCKS  one-hot grant; a transfer occurs on valid&ready.
REQ-008 i_clear  in  NUM_STOCKS  per-stock window clear.
REQ-009 i_stall  in  1  downstream stats backpressure; blocks new grants.
REQ-010 o_mem_write_en / o_mem_write_addr / o_mem_write_data  out  1 / ADDR_WIDTH / DATA_WIDTH  price buffer memory write port.
REQ-011 o_upd_valid / o_upd_stock_id / o_upd_count / o_upd_evict  out  1 / SID_W / CNT_W / 1  update descriptor for moving-stats block.

Function
REQ-012 Per stock k, controller SHALL hold write pointer ptr[k] (PTR_W) and fill count cnt[k] (CNT_W).
REQ-013 Arbitration: round-robin over i_req_valid & ~i_clear, masked to zero when i_stall=1; o_req_ready combinational, at most one bit set.
REQ-014 Priority pointer SHALL be 0 after reset; after grant to k, highest priority moves to (k+1) mod NUM_STOCKS; unchanged when no grant.
REQ-015 Pipeline stage W (cycle N+1 after accept in cycle N): o_mem_write_en=1, o_mem_write_addr = k*BUFFER_SIZE + ptr[k] (value at accept), o_mem_write_data = accepted price, all registered.
REQ-016 On accept: ptr[k] <= (ptr[k]==BUFFER_SIZE-1) ? 0 : ptr[k]+1; cnt[k] <= min(cnt[k]+1, BUFFER_SIZE).
REQ-017 Stage U (cycle N+2): o_upd_valid=1 for one cycle, aligned to memory outgoing-price output; o_upd_stock_id=k; o_upd_count = post-increment count; o_upd_evict=1 iff cnt[k]==BUFFER_SIZE at accept (outgoing price valid).
REQ-018 Throughput: one accept per cycle sustained; back-to-back accepts to the same stock SHALL use consecutive pointers.
REQ-019 i_stall SHALL block only new grants; operations already in stage W or U SHALL complete.
REQ-020 i_clear[k]=1: ptr[k] and cnt[k] <= 0 next edge; clear overrides an accept-update for k in the same cycle (k is not granted that cycle); in-flight W/U ops for k SHALL complete with their captured values.
REQ-021 Multiple i_clear bits SHALL act independently and simultaneously.
REQ-022 o_mem_write_en and o_upd_valid SHALL be 0 in any cycle without a corresponding earlier accept; data/addr/id outputs hold last value when idle.

Reset
REQ-023 On i_rst=1 (asynchronous): all ptr, cnt, priority pointer, stage W and U registers SHALL be 0; o_mem_write_en=0, o_upd_valid=0, o_req_ready=0 while i_rst=1.
REQ-024 Reset mid-operation SHALL drop in-flight W/U operations; no write or update emitted for them after reset deasserts.
REQ-025 First grant possible in the first rising edge with i_rst=0.

Verification
REQ-026 Single write: stock 2 valid, price 0x64, from reset -> accept cycle 0; cycle 1 write_en=1, addr=128, data=0x64; cycle 2 upd_valid=1, id=2, count=1, evict=0.
REQ-027 Round-robin: all four valid continuously, i_stall=0 -> grants 0,1,2,3,0,... one per cycle; addrs 0,64,128,192,1,...
REQ-028 Wrap/saturate: 65 accepts to stock 1 -> 64th write addr 127, count 64, evict 0; 65th write addr 64, count 64, evict 1.
REQ-029 Stall: i_stall=1 for 3 cycles with requests pending -> o_req_ready=0, no new writes; in-flight write and update still issued; grants resume on next cycle after stall drops, priority preserved.
REQ-030 Clear collision: stock 0 at count 10, i_clear[0]=1 with i_req_valid[0]=1 -> no grant to 0 that cycle; next accept to 0 writes addr 0, count 1, evict 0.
REQ-031 Async reset: assert i_rst between accept and upd_valid -> write_en and upd_valid drop immediately, no update after release, next stock 3 accept writes addr 192.
